// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes driven to the vending FSM and
// the coin-acceptor state encoding.
package vm_pkg;

    localparam logic [2:0] COIN_NONE = 3'd0;
    localparam logic [2:0] COIN_1    = 3'd1;
    localparam logic [2:0] COIN_2    = 3'd2;
    localparam logic [2:0] COIN_5    = 3'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GAP      = 2'd1,
        WAIT_REL = 2'd2
    } acc_state_e;

    // press bit 0/1/2 = 1/2/5-unit button; anything but a single hot bit maps to no coin
    function automatic logic [2:0] coin_code(input logic [2:0] press);
        case (press)
            3'b001:  coin_code = COIN_1;
            3'b010:  coin_code = COIN_2;
            3'b100:  coin_code = COIN_5;
            default: coin_code = COIN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-FF synchroniser, debounce counter, and a one-cycle pulse on
// the rising edge of the debounced level.
module btn_debounce #(
    parameter int unsigned DB_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             prev_q,  prev_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // NOTE: every variable gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        prev_d  = level_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: non-blocking assignments keep the two synchroniser stages a true shift
    // register; blocking ones would collapse them into a single flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: three debounced buttons -> one-cycle coin codes for the vending FSM.
// Define COIN_AUDIT_EN to build the saturating accept/reject audit counters.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int unsigned DB_CYC  = 1000000,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_1,
    input  logic       btn_2,
    input  logic       btn_5,
    output logic [2:0] coin,
    output logic       coin_valid,
    output logic       reject,
    output logic       busy,
    output logic [7:0] accept_cnt,
    output logic [7:0] reject_cnt
);

    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    logic [2:0] level;
    logic [2:0] press;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_1 (.clk(clk), .rst(rst), .btn_raw(btn_1), .level(level[0]), .rise(press[0]));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_2 (.clk(clk), .rst(rst), .btn_raw(btn_2), .level(level[1]), .rise(press[1]));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_5 (.clk(clk), .rst(rst), .btn_raw(btn_5), .level(level[2]), .rise(press[2]));

    acc_state_e       state_q,  state_d;
    logic [GAP_W-1:0] gap_q,    gap_d;
    logic [2:0]       coin_q,   coin_d;
    logic             valid_q,  valid_d;
    logic             reject_q, reject_d;
    logic             busy_q,   busy_d;

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        coin_d   = COIN_NONE;
        valid_d  = 1'b0;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                if ($countones(press) == 1) begin
                    coin_d  = coin_code(press);
                    valid_d = 1'b1;
                    gap_d   = GAP_W'(GAP_CYC);
                    state_d = GAP;
                end else if (press != 3'b000) begin
                    reject_d = 1'b1;
                    state_d  = WAIT_REL;
                end
            end
            // presses arriving here are dropped, not queued
            GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    state_d = WAIT_REL;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            WAIT_REL: begin
                if (level == 3'b000) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            coin_q   <= COIN_NONE;
            valid_q  <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            coin_q   <= coin_d;
            valid_q  <= valid_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    assign coin       = coin_q;
    assign coin_valid = valid_q;
    assign reject     = reject_q;
    assign busy       = busy_q;

`ifdef COIN_AUDIT_EN
    logic [7:0] accept_cnt_q, accept_cnt_d;
    logic [7:0] reject_cnt_q, reject_cnt_d;

    always_comb begin
        accept_cnt_d = accept_cnt_q;
        reject_cnt_d = reject_cnt_q;
        if (valid_q && accept_cnt_q != 8'hFF) begin
            accept_cnt_d = accept_cnt_q + 8'd1;
        end
        if (reject_q && reject_cnt_q != 8'hFF) begin
            reject_cnt_d = reject_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accept_cnt_q <= '0;
            reject_cnt_q <= '0;
        end else begin
            accept_cnt_q <= accept_cnt_d;
            reject_cnt_q <= reject_cnt_d;
        end
    end

    assign accept_cnt = accept_cnt_q;
    assign reject_cnt = reject_cnt_q;
`else
    assign accept_cnt = '0;
    assign reject_cnt = '0;
`endif

endmodule
